svm_coef_loader: RTL and testbench
==================================

# svm_coef_loader

Configuration controller for the SVM classifier datapath. It accepts a narrow stream of coefficient words from the host or config bus under a valid/ready handshake. It packs every N_COEF words into one wide row and writes the 36 rows into the classifier's coefficient RAM port A. It then loads the bias word and raises `cfg_valid`, which the top level uses to gate HOG features into the classifier.

## Interface
- `COEF_W`, 12, width of one coefficient / bias word
- `N_COEF`, 105, coefficients per RAM row (15 x 7 window blocks)
- `N_ROW`, 36, rows per model
- `ADDR_W`, 6, RAM address width (ceil log2 N_ROW)
- `RAM_DW`, COEF_W*N_COEF, RAM row width

- `clk` in 1: clock
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: single-cycle request to begin a model load
- `abort` in 1: cancel an in-progress load
- `s_valid` in 1: stream word valid
- `s_ready` out 1: stream word accepted when `s_valid & s_ready`
- `s_data` in COEF_W: stream word
- `ram_addr` out ADDR_W: RAM port A address
- `ram_we` out 1: RAM port A write enable
- `ram_data` out RAM_DW: RAM port A write data
- `bias` out COEF_W: bias value
- `b_load` out 1: one-cycle bias load strobe
- `busy` out 1: load in progress
- `cfg_valid` out 1: complete model present

## Operation
- States: IDLE, FILL, WRITE, BIAS, DONE. All outputs are decoded from registered state and counters. There is no combinational path from `s_valid`/`s_data` to any output.
- IDLE: `s_ready`=0. `start` -> FILL, with word counter `wcnt`=0 and row counter `rcnt`=0.
- FILL: `s_ready`=1. Each accepted word:
  - shifts into the row register: `row <= {s_data, row[RAM_DW-1:COEF_W]}`;
  - increments `wcnt`.
  - The acceptance with `wcnt`==N_COEF-1 -> WRITE and clears `wcnt`.
  - Result: the k-th word of a row ends at `ram_data[COEF_W*k +: COEF_W]` (coef index k).
- WRITE: exactly one cycle, `s_ready`=0.
  - `ram_we`=1, `ram_addr`=`rcnt`, `ram_data`=`row`.
  - Next: if `rcnt`==N_ROW-1 -> BIAS; else `rcnt`+1 -> FILL.
- BIAS: `s_ready`=1. On acceptance:
  - `bias` <= `s_data`;
  - `b_load` pulses high for the following cycle;
  - -> DONE.
- DONE: `cfg_valid`=1, `s_ready`=0. `start` -> FILL and clears `cfg_valid` in the same transition (reload).
- `busy` = state in {FILL, WRITE, BIAS}.
- `start` while busy is ignored.
- `abort` in any state -> IDLE next cycle:
  - clears `cfg_valid`, `wcnt`, `rcnt`;
  - rows already written remain in RAM;
  - the partial row is discarded, and `bias` keeps its old value.
- `abort` and `start` in the same cycle: `abort` wins.
- Stream words presented in IDLE, WRITE or DONE are not accepted (`s_ready`=0). The upstream holds them.
- `ram_addr` and `ram_data` hold their last values outside WRITE. Only `ram_we` qualifies them.

## Timing
- Reset (async, asserted): state=IDLE; `s_ready`, `ram_we`, `b_load`, `busy`, `cfg_valid` = 0; `ram_addr`=0, `ram_data`=0, `bias`=0; counters=0.
- Reset asserted mid-load: outputs go to reset values immediately. No `ram_we` is issued after the reset edge.
- `start` sampled at edge t -> `s_ready`=1 and `busy`=1 from cycle t+1.
- Word N_COEF of a row accepted at edge t -> `ram_we`=1 during cycle t+1 -> `s_ready`=1 again at t+2.
- Bias accepted at edge t -> `b_load`=1 and `cfg_valid`=1 during cycle t+1. `b_load` returns low at t+2.
- Minimum load with `s_valid` held high: N_ROW*(N_COEF+1)+1 = 3817 cycles from first `s_ready` to `cfg_valid`.
- Back-to-back accepts with no bubbles in FILL. Arbitrary `s_valid` gaps are tolerated and only stretch the load.

## Test plan
- Reset, then full load with `s_valid` always high, word value = global index mod 4096. Required:
  - 36 `ram_we` pulses, at addresses 0..35;
  - row r slot k = (r*105+k) mod 4096;
  - `bias`=3780 mod 4096 with `b_load` one cycle;
  - `cfg_valid` rises 3817 cycles after first `s_ready`.
- Same load with `s_valid` toggling pseudo-randomly (50%). Required: identical RAM contents, bias, and ordering; no word lost or duplicated.
- `abort` at row 10, word 50. Required:
  - next cycle `busy`=0, `s_ready`=0, `cfg_valid`=0;
  - no further `ram_we`;
  - a subsequent `start` rewrites from address 0.
- `start` pulses during FILL and BIAS. Required: ignored, with counters and output unchanged. `start` in DONE -> `cfg_valid` drops next cycle and the reload begins at address 0.
- Async `rst` low during a WRITE cycle. Required: `ram_we` drops without waiting for `clk`, and all outputs take their reset values.
- `abort`+`start` in the same cycle while in DONE. Required: IDLE, `cfg_valid`=0, no load started.

Source files
------------

// File: rtl/svm_coef_loader.sv
// Coefficient loader for the SVM classifier: packs a narrow word stream into
// wide RAM rows, writes N_ROW rows, then captures the bias and flags the model valid.
module svm_coef_loader #(
  parameter int COEF_W = 12,
  parameter int N_COEF = 105,
  parameter int N_ROW  = 36,
  parameter int ADDR_W = 6,
  parameter int RAM_DW = COEF_W * N_COEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [COEF_W-1:0] s_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [RAM_DW-1:0] ram_data,
  output logic [COEF_W-1:0] bias,
  output logic              b_load,
  output logic              busy,
  output logic              cfg_valid
);

  localparam int WC_W = $clog2(N_COEF);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    BIAS,
    DONE
  } state_t;

  state_t              r_state;
  logic [WC_W-1:0]     r_wcnt;
  logic [ADDR_W-1:0]   r_rcnt;
  logic [RAM_DW-1:0]   r_row;
  logic [RAM_DW-1:0]   r_ram_data;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_we;
  logic [COEF_W-1:0]   r_bias;
  logic                r_b_load;
  logic                r_s_ready;
  logic                r_busy;
  logic                r_cfg_valid;
  logic                w_accept;
  logic [RAM_DW-1:0]   w_row_next;

  assign w_accept   = s_valid & r_s_ready;
  // Newest word enters at the top so the first word of a row lands in slot 0.
  assign w_row_next = {s_data, r_row[RAM_DW-1:COEF_W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_row       <= '0;
      r_ram_data  <= '0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_bias      <= '0;
      r_b_load    <= 1'b0;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_valid <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      r_b_load <= 1'b0;
      if (abort) begin
        r_state     <= IDLE;
        r_wcnt      <= '0;
        r_rcnt      <= '0;
        r_s_ready   <= 1'b0;
        r_busy      <= 1'b0;
        r_cfg_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (start) begin
              r_state     <= FILL;
              r_wcnt      <= '0;
              r_rcnt      <= '0;
              r_s_ready   <= 1'b1;
              r_busy      <= 1'b1;
              r_cfg_valid <= 1'b0;
            end
          end
          FILL: begin
            if (w_accept) begin
              r_row <= w_row_next;
              if (r_wcnt == WC_W'(N_COEF - 1)) begin
                r_wcnt     <= '0;
                r_state    <= WRITE;
                r_s_ready  <= 1'b0;
                r_ram_we   <= 1'b1;
                r_ram_addr <= r_rcnt;
                r_ram_data <= w_row_next;
              end else begin
                r_wcnt <= r_wcnt + 1'b1;
              end
            end
          end
          WRITE: begin
            r_s_ready <= 1'b1;
            if (r_rcnt == ADDR_W'(N_ROW - 1)) begin
              r_state <= BIAS;
            end else begin
              r_rcnt  <= r_rcnt + 1'b1;
              r_state <= FILL;
            end
          end
          BIAS: begin
            if (w_accept) begin
              r_bias      <= s_data;
              r_b_load    <= 1'b1;
              r_state     <= DONE;
              r_s_ready   <= 1'b0;
              r_busy      <= 1'b0;
              r_cfg_valid <= 1'b1;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_ready   = r_s_ready;
  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_data  = r_ram_data;
  assign bias      = r_bias;
  assign b_load    = r_b_load;
  assign busy      = r_busy;
  assign cfg_valid = r_cfg_valid;

endmodule

// File: tb/tb_svm_coef_loader.sv
// Scoreboard bench for svm_coef_loader: expected RAM rows and bias are queued
// when a load is issued; a negedge monitor pops and compares on ram_we / b_load.
module tb_svm_coef_loader;

  localparam int COEF_W = 12;
  localparam int N_COEF = 105;
  localparam int N_ROW  = 36;
  localparam int ADDR_W = 6;
  localparam int RAM_DW = COEF_W * N_COEF;
  localparam int NW     = N_ROW * N_COEF + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [COEF_W-1:0] s_data = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [RAM_DW-1:0] ram_data;
  logic [COEF_W-1:0] bias;
  logic              b_load;
  logic              busy;
  logic              cfg_valid;

  svm_coef_loader #(
    .COEF_W(COEF_W), .N_COEF(N_COEF), .N_ROW(N_ROW), .ADDR_W(ADDR_W), .RAM_DW(RAM_DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data),
    .bias(bias), .b_load(b_load), .busy(busy), .cfg_valid(cfg_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [RAM_DW-1:0] data;
  } wr_t;

  wr_t               exp_q[$];
  logic [COEF_W-1:0] bias_q[$];
  logic [COEF_W-1:0] words [0:NW-1];
  logic [COEF_W-1:0] last_bias = '0;
  int                n_tests = 0;
  int                n_fail = 0;
  int                cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compares every RAM write and bias strobe against the scoreboard.
  initial begin
    wr_t e;
    logic prev_bload;
    logic [COEF_W-1:0] eb;
    prev_bload = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_bload = 1'b0;
      end else begin
        if (ram_we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected ram_we addr", 32'(ram_addr), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("ram_addr", 32'(ram_addr), 32'(e.addr));
            n_tests++;
            if (ram_data !== e.data) begin
              n_fail++;
              for (int k = 0; k < N_COEF; k++) begin
                if (ram_data[COEF_W*k +: COEF_W] !== e.data[COEF_W*k +: COEF_W]) begin
                  $display("FAIL ram_data row %0d slot %0d: got %0d expected %0d", e.addr, k,
                           ram_data[COEF_W*k +: COEF_W], e.data[COEF_W*k +: COEF_W]);
                  break;
                end
              end
            end
          end
        end
        if (prev_bload) chk("b_load one cycle", 32'(b_load), 32'd0);
        if (b_load) begin
          if (bias_q.size() == 0) begin
            chk("unexpected b_load bias", 32'(bias), 32'hFFFF_FFFF);
          end else begin
            eb = bias_q.pop_front();
            chk("bias", 32'(bias), 32'(eb));
            chk("cfg_valid with b_load", 32'(cfg_valid), 32'd1);
          end
        end
        prev_bload = b_load;
      end
    end
  end

  task automatic send_word(input logic [COEF_W-1:0] w, input int gap);
    logic acc;
    int guard;
    while ($urandom_range(0, 99) < gap) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    guard   = 0;
    acc     = 1'b0;
    while (!acc && guard < 1000) begin
      acc = s_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) chk("accept timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic pulse_start(input string nm);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " busy"}, 32'(busy), 32'd1);
    chk({nm, " s_ready"}, 32'(s_ready), 32'd1);
  endtask

  // Reference model: word r*N_COEF+k is slot k of row r; the last word is the bias.
  task automatic do_load(input int gap, input int abort_at, input bit poke,
                         input bit rnd, input bit timed);
    wr_t e;
    int  t0;
    int  nrow;
    for (int i = 0; i < NW; i++)
      words[i] = rnd ? COEF_W'($urandom_range(0, 4095)) : COEF_W'(i % 4096);
    nrow = (abort_at < 0) ? N_ROW : abort_at / N_COEF;
    for (int r = 0; r < nrow; r++) begin
      e.addr = ADDR_W'(r);
      for (int k = 0; k < N_COEF; k++) e.data[COEF_W*k +: COEF_W] = words[r*N_COEF + k];
      exp_q.push_back(e);
    end
    if (abort_at < 0) bias_q.push_back(words[NW-1]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    chk("start s_ready", 32'(s_ready), 32'd1);
    chk("start busy", 32'(busy), 32'd1);
    chk("start cfg_valid", 32'(cfg_valid), 32'd0);
    for (int i = 0; i < NW; i++) begin
      if (i == abort_at) break;
      if (poke && i == NW - 1) begin
        @(posedge clk); #1;
        pulse_start("start in BIAS");
      end
      send_word(words[i], gap);
      if (poke && i == 1234) pulse_start("start in FILL");
    end
    if (abort_at >= 0) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort s_ready", 32'(s_ready), 32'd0);
      chk("abort cfg_valid", 32'(cfg_valid), 32'd0);
      chk("abort bias kept", 32'(bias), 32'(last_bias));
      chk("abort rows left", 32'(exp_q.size()), 32'd0);
    end else begin
      chk("done cfg_valid", 32'(cfg_valid), 32'd1);
      chk("done busy", 32'(busy), 32'd0);
      chk("done s_ready", 32'(s_ready), 32'd0);
      if (timed) chk("load cycles", 32'(cyc - t0), 32'd3817);
      last_bias = words[NW-1];
      @(posedge clk); #1;
      chk("b_load low", 32'(b_load), 32'd0);
      chk("rows left", 32'(exp_q.size()), 32'd0);
      chk("bias left", 32'(bias_q.size()), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    chk("reset s_ready", 32'(s_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cfg_valid", 32'(cfg_valid), 32'd0);
    chk("reset ram_we", 32'(ram_we), 32'd0);
    chk("reset bias", 32'(bias), 32'd0);
    chk("reset ram_data", 32'(|ram_data), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    do_load(0, -1, 1'b0, 1'b0, 1'b1);
    do_load(50, -1, 1'b1, 1'b0, 1'b0);
    do_load(30, 10 * N_COEF + 50, 1'b0, 1'b1, 1'b0);

    s_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("post-abort idle s_ready", 32'(s_ready), 32'd0);
    chk("post-abort idle busy", 32'(busy), 32'd0);

    do_load(20, -1, 1'b0, 1'b1, 1'b0);

    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort+start cfg_valid", 32'(cfg_valid), 32'd0);
    chk("abort+start busy", 32'(busy), 32'd0);
    s_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("abort+start s_ready", 32'(s_ready), 32'd0);
    chk("abort+start stays idle", 32'(busy), 32'd0);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < N_COEF; i++) send_word(COEF_W'($urandom_range(0, 4095)), 10);
    chk("write cycle ram_we", 32'(ram_we), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("async rst ram_we", 32'(ram_we), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst s_ready", 32'(s_ready), 32'd0);
    chk("async rst cfg_valid", 32'(cfg_valid), 32'd0);
    chk("async rst b_load", 32'(b_load), 32'd0);
    chk("async rst ram_addr", 32'(ram_addr), 32'd0);
    chk("async rst bias", 32'(bias), 32'd0);
    chk("async rst ram_data", 32'(|ram_data), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("after rst idle busy", 32'(busy), 32'd0);
    chk("final rows left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
